// File: rtl/xmem_arbiter.sv
// Two-master Wishbone arbiter for the shared HyperRAM xmem bus: registered round-robin
// grant held for a whole CYC, plus an ack watchdog that terminates hung accesses.
module xmem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [29:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [29:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant,
  output logic        timeout_flag
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             last_owner;
  logic             wd_kill;
  logic [CNT_W-1:0] wd_cnt;
  logic [1:0]       err_q;
  logic             own_cyc;
  logic             own_stb;
  logic             ack_ok;

  // Owner-side request mux; everything is driven 0 while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    if (grant[0]) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
    end else if (grant[1]) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_stb & ~wd_kill;

  // Acks are only honoured for a live, un-killed owner cycle; stale acks vanish.
  assign ack_ok   = s_ack_i & own_cyc & ~wd_kill;
  assign m0_ack_o = ack_ok & grant[0];
  assign m1_ack_o = ack_ok & grant[1];
  assign m0_dat_o = m0_ack_o ? s_dat_i : '0;
  assign m1_dat_o = m1_ack_o ? s_dat_i : '0;
  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= 2'b00;
      last_owner   <= 1'b1;
      wd_kill      <= 1'b0;
      wd_cnt       <= '0;
      err_q        <= 2'b00;
      timeout_flag <= 1'b0;
    end else begin
      err_q <= 2'b00;
      case (state)
        IDLE: begin
          wd_cnt  <= '0;
          wd_kill <= 1'b0;
          if (m0_cyc_i && (!m1_cyc_i || FIXED_PRIORITY || last_owner)) begin
            state <= OWN0;
            grant <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= OWN1;
            grant <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            // Always pass through IDLE so s_cyc_o drops between owners.
            state      <= IDLE;
            grant      <= 2'b00;
            last_owner <= (state == OWN1);
            wd_cnt     <= '0;
            wd_kill    <= 1'b0;
          end else if (own_stb && !s_ack_i && !wd_kill) begin
            if (wd_cnt == WD_LAST) begin
              wd_kill      <= 1'b1;
              err_q        <= grant;
              timeout_flag <= 1'b1;
              wd_cnt       <= '0;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end else begin
            wd_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed bench for xmem_arbiter: dut_a is round-robin, dut_b fixed-priority, both with
// an 8-cycle watchdog, driven from the same master/slave stimulus.
module tb_xmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat, s_dat;
  logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc, s_ack;
  logic [3:0]  m0_sel, m1_sel;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_dat, b_m0_dat, b_m1_dat, b_s_dat;
  logic [29:0] a_s_adr, b_s_adr;
  logic [3:0]  a_s_sel, b_s_sel;
  logic [1:0]  a_grant, b_grant;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_we, a_s_stb, a_s_cyc, a_flag;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_we, b_s_stb, b_s_cyc, b_flag;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  xmem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(a_m0_ack),
    .m0_err_o(a_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(a_m1_ack),
    .m1_err_o(a_m1_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
    .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant(a_grant), .timeout_flag(a_flag)
  );

  xmem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(b_m0_ack),
    .m0_err_o(b_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(b_m1_ack),
    .m1_err_o(b_m1_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
    .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .grant(b_grant), .timeout_flag(b_flag)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_sel = 4'h0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_sel = 4'h0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_dat = '0; s_ack = 1'b0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    clear_inputs();
    #2;
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL reset_grant got %b exp 00", a_grant); end
    vecs++; if (a_flag !== 1'b0) begin errs++; $display("FAIL reset_flag got %b exp 0", a_flag); end
    vecs++; if ({a_s_cyc, a_s_stb, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err} !== 6'b0) begin
      errs++; $display("FAIL reset_strobes got %b exp 000000",
                       {a_s_cyc, a_s_stb, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err}); end
    vecs++; if (b_grant !== 2'b00) begin errs++; $display("FAIL reset_grant_b got %b exp 00", b_grant); end
    #10;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h100; m0_sel = 4'hF; m0_we = 1'b0;
    settle();
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL read_latency got %b exp 00", a_grant); end
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL read_grant got %b exp 01", a_grant); end
    vecs++; if (a_s_adr !== 30'h100) begin errs++; $display("FAIL read_adr got %h exp 100", a_s_adr); end
    vecs++; if ({a_s_cyc, a_s_stb} !== 2'b11) begin errs++; $display("FAIL read_cyc_stb got %b exp 11", {a_s_cyc, a_s_stb}); end
    s_dat = 32'hDEADBEEF; s_ack = 1'b1;
    settle();
    vecs++; if (a_m0_ack !== 1'b1) begin errs++; $display("FAIL read_ack got %b exp 1", a_m0_ack); end
    vecs++; if (a_m0_dat !== 32'hDEADBEEF) begin errs++; $display("FAIL read_dat got %h exp deadbeef", a_m0_dat); end
    vecs++; if (a_m1_ack !== 1'b0) begin errs++; $display("FAIL read_m1_ack got %b exp 0", a_m1_ack); end
    tick();
    clear_inputs();
    tick();
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL read_release got %b exp 00", a_grant); end
  endtask

  task automatic test_round_robin;
    do_reset();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL rr_first got %b exp 01", a_grant); end
    m0_cyc = 1'b0;
    tick();
    vecs++; if ({a_grant, a_s_cyc} !== 3'b000) begin errs++; $display("FAIL rr_idle got %b exp 000", {a_grant, a_s_cyc}); end
    tick();
    vecs++; if (a_grant !== 2'b10) begin errs++; $display("FAIL rr_second got %b exp 10", a_grant); end
    vecs++; if (a_s_cyc !== 1'b1) begin errs++; $display("FAIL rr_second_cyc got %b exp 1", a_s_cyc); end
    m1_cyc = 1'b0;
    tick();
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL rr_idle2 got %b exp 00", a_grant); end
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL rr_third got %b exp 01", a_grant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_fixed_priority;
    do_reset();
    m1_cyc = 1'b1;
    tick();
    vecs++; if (b_grant !== 2'b10) begin errs++; $display("FAIL fp_m1_hold got %b exp 10", b_grant); end
    m0_cyc = 1'b1;
    tick();
    vecs++; if (b_grant !== 2'b10) begin errs++; $display("FAIL fp_no_preempt got %b exp 10", b_grant); end
    m1_cyc = 1'b0;
    tick();
    vecs++; if (b_grant !== 2'b00) begin errs++; $display("FAIL fp_idle got %b exp 00", b_grant); end
    tick();
    vecs++; if (b_grant !== 2'b01) begin errs++; $display("FAIL fp_m0_next got %b exp 01", b_grant); end
    m0_cyc = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      tick();
      vecs++; if (b_grant !== 2'b01) begin errs++; $display("FAIL fp_tie%0d got %b exp 01", i, b_grant); end
      if (i == 0) begin
        vecs++; if (a_grant !== 2'b10) begin errs++; $display("FAIL rr_tie_after_m0 got %b exp 10", a_grant); end
      end
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_timeout;
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 30'h200; m1_dat = 32'h12345678; m1_sel = 4'hF;
    tick();
    vecs++; if (a_grant !== 2'b10) begin errs++; $display("FAIL wd_grant got %b exp 10", a_grant); end
    vecs++; if ({a_s_we, a_s_stb} !== 2'b11) begin errs++; $display("FAIL wd_we_stb got %b exp 11", {a_s_we, a_s_stb}); end
    vecs++; if (a_s_dat !== 32'h12345678) begin errs++; $display("FAIL wd_wdat got %h exp 12345678", a_s_dat); end
    for (int i = 1; i < 8; i++) begin
      tick();
      vecs++; if ({a_m1_err, a_s_stb} !== 2'b01) begin
        errs++; $display("FAIL wd_wait%0d err_stb got %b exp 01", i, {a_m1_err, a_s_stb}); end
    end
    tick();
    vecs++; if (a_m1_err !== 1'b1) begin errs++; $display("FAIL wd_err got %b exp 1", a_m1_err); end
    vecs++; if (a_m0_err !== 1'b0) begin errs++; $display("FAIL wd_m0_err got %b exp 0", a_m0_err); end
    vecs++; if (a_s_stb !== 1'b0) begin errs++; $display("FAIL wd_stb_kill got %b exp 0", a_s_stb); end
    vecs++; if (a_flag !== 1'b1) begin errs++; $display("FAIL wd_flag got %b exp 1", a_flag); end
    s_ack = 1'b1;
    settle();
    vecs++; if (a_m1_ack !== 1'b0) begin errs++; $display("FAIL wd_late_ack got %b exp 0", a_m1_ack); end
    tick();
    s_ack = 1'b0;
    vecs++; if (a_m1_err !== 1'b0) begin errs++; $display("FAIL wd_err_pulse got %b exp 0", a_m1_err); end
    vecs++; if (a_s_stb !== 1'b0) begin errs++; $display("FAIL wd_stb_held got %b exp 0", a_s_stb); end
    clear_inputs();
    tick();
    vecs++; if ({a_grant, a_flag} !== 3'b001) begin errs++; $display("FAIL wd_release got %b exp 001", {a_grant, a_flag}); end
    tick();
  endtask

  task automatic test_ack_at_fire;
    do_reset();
    settle();
    vecs++; if (a_flag !== 1'b0) begin errs++; $display("FAIL flag_reset got %b exp 0", a_flag); end
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h040; m0_sel = 4'hF;
    tick();
    for (int i = 0; i < 7; i++) tick();
    s_ack = 1'b1; s_dat = 32'h0BADCAFE;
    settle();
    vecs++; if (a_m0_ack !== 1'b1) begin errs++; $display("FAIL race_ack got %b exp 1", a_m0_ack); end
    tick();
    s_ack = 1'b0; m0_stb = 1'b0;
    vecs++; if ({a_m0_err, a_flag} !== 2'b00) begin errs++; $display("FAIL race_err_flag got %b exp 00", {a_m0_err, a_flag}); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h300; m0_sel = 4'hF;
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL mid_own got %b exp 01", a_grant); end
    #2;
    reset_n = 1'b0;
    #1;
    vecs++; if ({a_grant, a_s_cyc, a_s_stb} !== 4'b0000) begin
      errs++; $display("FAIL mid_async got %b exp 0000", {a_grant, a_s_cyc, a_s_stb}); end
    clear_inputs();
    #1;
    reset_n = 1'b1;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h300; m0_sel = 4'hF;
    settle();
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL mid_rearb_lat got %b exp 00", a_grant); end
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL mid_rearb got %b exp 01", a_grant); end
    s_ack = 1'b1; s_dat = 32'hCAFEF00D;
    settle();
    vecs++; if ({a_m0_ack, a_m0_dat} !== {1'b1, 32'hCAFEF00D}) begin
      errs++; $display("FAIL mid_read got %b/%h exp 1/cafef00d", a_m0_ack, a_m0_dat); end
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_protocol_violation;
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    m0_cyc = 1'b0;
    tick();
    m0_stb = 1'b0;
    s_ack = 1'b1;
    settle();
    vecs++; if ({a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack} !== 4'b0000) begin
      errs++; $display("FAIL stray_ack got %b exp 0000", {a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack}); end
    vecs++; if (a_grant !== 2'b00) begin errs++; $display("FAIL stray_grant got %b exp 00", a_grant); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h010; m1_cyc = 1'b1;
    tick();
    s_ack = 1'b1; s_dat = 32'h11112222;
    settle();
    vecs++; if ({a_grant, a_m0_ack} !== 3'b011) begin errs++; $display("FAIL b2b_ack1 got %b exp 011", {a_grant, a_m0_ack}); end
    tick();
    s_ack = 1'b0; m0_stb = 1'b0;
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL b2b_hold got %b exp 01", a_grant); end
    m0_stb = 1'b1; m0_adr = 30'h011; s_ack = 1'b1; s_dat = 32'h33334444;
    settle();
    vecs++; if ({a_m0_ack, a_m1_ack, a_m0_dat} !== {2'b10, 32'h33334444}) begin
      errs++; $display("FAIL b2b_ack2 got %b%b/%h exp 10/33334444", a_m0_ack, a_m1_ack, a_m0_dat); end
    vecs++; if (a_s_adr !== 30'h011) begin errs++; $display("FAIL b2b_adr got %h exp 011", a_s_adr); end
    tick();
    vecs++; if (a_grant !== 2'b01) begin errs++; $display("FAIL b2b_hold2 got %b exp 01", a_grant); end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_ack_at_fire();
    test_reset_mid();
    test_protocol_violation();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
